frog_ctrl: RTL
==============

FROG_CTRL -- requirements
Module: frog_ctrl

Interface
REQ-001 Parameters (name, default, meaning):
- X_MIN, 96, left edge of play field in pixels
- X_MAX, 544, exclusive right edge of play field
- Y_MAX, 480, exclusive bottom edge
- STEP, 32, hop distance in pixels
- SIZE, 32, frog square size
- START_X, 320, spawn column
- START_Y, 448, spawn row
- HOP_FRAMES, 8, cooldown frames after a hop
- DEATH_FRAMES, 32, death animation frames
- LIVES, 3, lives per game
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, pixel clock; single clock domain
- rst_n, in, 1, asynchronous active-low reset
- frame_tick, in, 1, one-cycle pulse once per frame at start of vertical blanking
- btn_up / btn_down / btn_left / btn_right, in, 1 each, synchronized active-high button levels
- collision, in, 1, frog overlaps hazard; sampled only on frame_tick
- square_x, out, 10, frog left edge
- square_y, out, 10, frog top edge
- square_size, out, 10, frog size; 0 hides the frog
- lives, out, 2, remaining lives
- score, out, 8, completed crossings
- game_over, out, 1, high while in GAME_OVER
- win_pulse, out, 1, one-cycle pulse on a completed crossing

Function
REQ-003 States: PLAY, COOLDOWN, DYING, GAME_OVER. All state, position, counter and output updates occur only on a clk edge where frame_tick=1, except press latching (REQ-004) and win_pulse deassertion (REQ-008).
REQ-004 Each button has a pending bit, set on a 0->1 edge of that button (edge detected against the previous-cycle level); all pending bits clear on every frame_tick in every state; a press is consumed only if it is pending before its tick.
REQ-005 PLAY: if collision=1 at the tick, go to DYING (collision beats any move); else if any pending bit is set, apply one move with priority up > down > left > right.
REQ-006 Move legality:
- up: y >= STEP
- down: y+STEP+SIZE <= Y_MAX
- left: x-STEP >= X_MIN
- right: x+STEP+SIZE <= X_MAX
- An illegal highest-priority move does nothing: no fallback to a lower priority; stay in PLAY; no cooldown.
REQ-007 A legal move updates the position, loads the cooldown counter with HOP_FRAMES and enters COOLDOWN.
REQ-008 Win: a legal up move that gives y=0 instead sets position to (START_X, START_Y) and increments score (8-bit wrap 255->0). win_pulse is high for exactly the one clk cycle after that tick. Then COOLDOWN per REQ-007.
REQ-009 COOLDOWN: each tick decrements the counter; the tick that decrements it from 1 returns to PLAY, so cooldown spans exactly HOP_FRAMES ticks. Presses are discarded. collision=1 at any tick in COOLDOWN enters DYING.
REQ-010 Entering DYING: decrement lives and load the death counter with DEATH_FRAMES. Position is frozen. square_size = 0 when death_counter[2]=1, else SIZE.
REQ-011 DYING: decrement the counter each tick. On the tick that decrements it from 1:
- if lives=0: go to GAME_OVER
- else: position = (START_X, START_Y), go to PLAY
REQ-012 GAME_OVER: game_over=1, square_size=SIZE, position frozen, collision ignored. Any pending bit at a tick restarts the game: lives=LIVES, score=0, position=(START_X, START_Y), go to PLAY.
REQ-013 square_size = SIZE in every state except as given in REQ-010.
REQ-014 All arithmetic is 10-bit unsigned; legality checks are evaluated before the update, so no wrap can occur.

Reset
REQ-015 rst_n=0 asynchronously forces:
- state=PLAY, square_x=START_X, square_y=START_Y, square_size=SIZE
- lives=LIVES, score=0, game_over=0, win_pulse=0
- all pending bits, edge registers and counters to 0
REQ-016 Reset asserted mid-hop, mid-death or in GAME_OVER gives the REQ-015 state immediately, with no residual pending press after release.

Verification
REQ-017 Directed scenarios:
- Reset, press right, tick -> x=352, y=448, COOLDOWN; press right again during the next 8 ticks -> no move; after the 8th tick, press+tick -> x=384.
- From (320,448), press up and left together, tick -> y=416, x=320 (priority).
- Frog at x=96, press left, tick -> x=96, state PLAY; press right, next tick -> x=128.
- Collision=1 on the same tick as a pending up -> no move, lives 3->2, DYING; square_size toggles 32/0 every 4 ticks; after 32 ticks -> (320,448), PLAY.
- Frog at y=32, press up, tick -> position (320,448), score 0->1, win_pulse high for one clk.
- Three collisions -> lives=0, game_over=1 after the third death; press any button, tick -> lives=3, score=0, PLAY. rst_n pulse during DYING -> REQ-015 values immediately.

Source files
------------

// File: rtl/frog_ctrl_if.sv
// Frog controller bus: frame/button/collision inputs and frog sprite/status outputs.
interface frog_ctrl_if;
  logic       frame_tick;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       collision;
  logic [9:0] square_x;
  logic [9:0] square_y;
  logic [9:0] square_size;
  logic [1:0] lives;
  logic [7:0] score;
  logic       game_over;
  logic       win_pulse;

  // Stimulus side (video timing, buttons, hazard detector)
  modport master (
    output frame_tick, btn_up, btn_down, btn_left, btn_right, collision,
    input  square_x, square_y, square_size, lives, score, game_over, win_pulse
  );

  // Controller side
  modport slave (
    input  frame_tick, btn_up, btn_down, btn_left, btn_right, collision,
    output square_x, square_y, square_size, lives, score, game_over, win_pulse
  );
endinterface

// File: rtl/frog_ctrl.sv
// Frog controller: frame-paced hop/cooldown/death/game-over state machine.
// Button presses are edge-latched between frame ticks and consumed on the tick.
module frog_ctrl #(
  parameter int X_MIN        = 96,
  parameter int X_MAX        = 544,
  parameter int Y_MAX        = 480,
  parameter int STEP         = 32,
  parameter int SIZE         = 32,
  parameter int START_X      = 320,
  parameter int START_Y      = 448,
  parameter int HOP_FRAMES   = 8,
  parameter int DEATH_FRAMES = 32,
  parameter int LIVES        = 3
) (
  input logic         clk,
  input logic         rst_n,
  frog_ctrl_if.slave  bus
);
  // One counter serves both cooldown and death; needs bit 2 for the blink.
  localparam int CMAX = (DEATH_FRAMES > HOP_FRAMES) ? DEATH_FRAMES : HOP_FRAMES;
  localparam int CW   = ($clog2(CMAX + 1) < 3) ? 3 : $clog2(CMAX + 1);

  localparam logic [9:0] XMIN_V  = 10'(X_MIN);
  localparam logic [9:0] XMAX_V  = 10'(X_MAX);
  localparam logic [9:0] YMAX_V  = 10'(Y_MAX);
  localparam logic [9:0] STEP_V  = 10'(STEP);
  localparam logic [9:0] SIZE_V  = 10'(SIZE);
  localparam logic [9:0] SX_V    = 10'(START_X);
  localparam logic [9:0] SY_V    = 10'(START_Y);

  // Pending/button bit order
  localparam int B_UP = 3, B_DN = 2, B_LF = 1, B_RT = 0;

  typedef enum logic [1:0] {PLAY, COOLDOWN, DYING, GAME_OVER} state_t;

  state_t        state_q, state_d;
  logic [9:0]    x_q, x_d, y_q, y_d;
  logic [1:0]    lives_q, lives_d;
  logic [7:0]    score_q, score_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          win_q, win_d;
  logic [3:0]    btn, btn_prev, pend;

  logic          up_ok, dn_ok, lf_ok, rt_ok;
  logic [9:0]    y_up;

  assign btn = {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right};

  // Latch rising edges between ticks; every tick flushes them, used or not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_prev <= '0;
      pend     <= '0;
    end else begin
      btn_prev <= btn;
      pend     <= bus.frame_tick ? 4'b0 : (pend | (btn & ~btn_prev));
    end
  end

  // Legality is checked on the current position, so updates never wrap.
  always_comb begin
    up_ok = (y_q >= STEP_V);
    dn_ok = ((y_q + STEP_V + SIZE_V) <= YMAX_V);
    lf_ok = (x_q >= (XMIN_V + STEP_V));
    rt_ok = ((x_q + STEP_V + SIZE_V) <= XMAX_V);
    y_up  = y_q - STEP_V;
  end

  // Next-state and datapath; nothing moves except on a frame tick.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    lives_d = lives_q;
    score_d = score_q;
    cnt_d   = cnt_q;
    win_d   = 1'b0;
    if (bus.frame_tick) begin
      unique case (state_q)
        PLAY: begin
          if (bus.collision) begin
            state_d = DYING;
            lives_d = lives_q - 2'd1;
            cnt_d   = CW'(DEATH_FRAMES);
          end else if (pend[B_UP]) begin
            if (up_ok) begin
              state_d = COOLDOWN;
              cnt_d   = CW'(HOP_FRAMES);
              if (y_up == 10'd0) begin
                // Reached the far bank: score and respawn.
                x_d     = SX_V;
                y_d     = SY_V;
                score_d = score_q + 8'd1;
                win_d   = 1'b1;
              end else begin
                y_d = y_up;
              end
            end
          end else if (pend[B_DN]) begin
            if (dn_ok) begin
              y_d     = y_q + STEP_V;
              state_d = COOLDOWN;
              cnt_d   = CW'(HOP_FRAMES);
            end
          end else if (pend[B_LF]) begin
            if (lf_ok) begin
              x_d     = x_q - STEP_V;
              state_d = COOLDOWN;
              cnt_d   = CW'(HOP_FRAMES);
            end
          end else if (pend[B_RT]) begin
            if (rt_ok) begin
              x_d     = x_q + STEP_V;
              state_d = COOLDOWN;
              cnt_d   = CW'(HOP_FRAMES);
            end
          end
        end
        COOLDOWN: begin
          if (bus.collision) begin
            state_d = DYING;
            lives_d = lives_q - 2'd1;
            cnt_d   = CW'(DEATH_FRAMES);
          end else begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = PLAY;
          end
        end
        DYING: begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            if (lives_q == 2'd0) begin
              state_d = GAME_OVER;
            end else begin
              state_d = PLAY;
              x_d     = SX_V;
              y_d     = SY_V;
            end
          end
        end
        GAME_OVER: begin
          if (|pend) begin
            state_d = PLAY;
            lives_d = 2'(LIVES);
            score_d = 8'd0;
            x_d     = SX_V;
            y_d     = SY_V;
          end
        end
        default: state_d = PLAY;
      endcase
    end
  end

  // Game state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PLAY;
      x_q     <= SX_V;
      y_q     <= SY_V;
      lives_q <= 2'(LIVES);
      score_q <= 8'd0;
      cnt_q   <= '0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      lives_q <= lives_d;
      score_q <= score_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
    end
  end

  assign bus.square_x    = x_q;
  assign bus.square_y    = y_q;
  assign bus.square_size = ((state_q == DYING) && cnt_q[2]) ? 10'd0 : SIZE_V;
  assign bus.lives       = lives_q;
  assign bus.score       = score_q;
  assign bus.game_over   = (state_q == GAME_OVER);
  assign bus.win_pulse   = win_q;
endmodule
